// File: rtl/raster_sample_packer_pkg.sv
// Shared encodings for raster_sample_packer and its halfword DMA writer.
package raster_sample_packer_pkg;

  localparam int unsigned STATE_WID = 3;

  localparam logic [STATE_WID-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_WID-1:0] ST_WR_LO   = 3'd1;
  localparam logic [STATE_WID-1:0] ST_WAIT_LO = 3'd2;
  localparam logic [STATE_WID-1:0] ST_WR_HI   = 3'd3;
  localparam logic [STATE_WID-1:0] ST_WAIT_HI = 3'd4;
  localparam logic [STATE_WID-1:0] ST_ACK     = 3'd5;

  localparam int unsigned HALF_LO_OFS      = 0;
  localparam int unsigned HALF_HI_OFS      = 2;
  localparam int unsigned BYTES_PER_SAMPLE = 4;
  localparam int unsigned SAMPLE_WID       = 32;

endpackage

// File: rtl/raster_dma_halfword_writer.sv
// Runs one halfword commit/finished handshake towards the DMA port; the caller sequences
// it twice per sample. Address and data are captured at commit and held until finished.
module raster_dma_halfword_writer #(
  parameter int unsigned WORD_WID = 16,
  parameter int unsigned ADDR_WID = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [ADDR_WID-1:0] addr,
  input  logic [WORD_WID-1:0] data,
  output logic                done,
  output logic [ADDR_WID-1:0] dma_addr,
  output logic [WORD_WID-1:0] dma_data,
  output logic                dma_commit,
  input  logic                dma_finished
);

  logic                commit_q, commit_d;
  logic [ADDR_WID-1:0] addr_q, addr_d;
  logic [WORD_WID-1:0] data_q, data_d;

  always_comb begin
    commit_d = commit_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (!commit_q) begin
      // A finished left high by the previous write must drop before the next commit.
      if (go && !dma_finished) begin
        commit_d = 1'b1;
        addr_d   = addr;
        data_d   = data;
      end
    end else if (dma_finished) begin
      commit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      commit_q <= commit_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign done       = commit_q & dma_finished;
  assign dma_commit = commit_q;
  assign dma_addr   = addr_q;
  assign dma_data   = data_q;

endmodule

// File: rtl/raster_sample_packer.sv
// Sign-extends scanner samples to 32 bits and writes them as two halfwords into a circular
// buffer. Define RASTER_PACKER_DROP_EN to drop samples on a full buffer instead of stalling.
module raster_sample_packer
  import raster_sample_packer_pkg::*;
#(
  parameter int unsigned          DATA_WID  = 24,
  parameter int unsigned          WORD_WID  = 16,
  parameter int unsigned          ADDR_WID  = 32,
  parameter int unsigned          PTR_WID   = 11,
  parameter logic [ADDR_WID-1:0]  BASE_ADDR = 32'h0010_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_WID-1:0] data,
  input  logic                mem_commit,
  output logic                mem_finished,
  input  logic [PTR_WID-1:0]  rd_ptr,
  input  logic                flush,
  output logic [PTR_WID-1:0]  wr_ptr,
  output logic [ADDR_WID-1:0] dma_addr,
  output logic [WORD_WID-1:0] dma_data,
  output logic                dma_commit,
  input  logic                dma_finished,
  output logic                overflow
);

  localparam logic [PTR_WID-1:0] PTR_ONE = 1;

  logic [STATE_WID-1:0]  state_q, state_d;
  logic [PTR_WID-1:0]    wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic                  overflow_q, overflow_d;
  logic [SAMPLE_WID-1:0] latch_q, latch_d, sample_ext;
  logic                  full, hi_half, wr_go, wr_done;
  logic [ADDR_WID-1:0]   slot_addr, half_addr;
  logic [WORD_WID-1:0]   half_data;

  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
  assign full       = (wr_ptr_inc == rd_ptr);
  assign sample_ext = {{(SAMPLE_WID - DATA_WID){data[DATA_WID-1]}}, data};

  assign slot_addr = BASE_ADDR + ADDR_WID'(wr_ptr_q) * ADDR_WID'(BYTES_PER_SAMPLE);
  assign hi_half   = (state_q == ST_WR_HI) || (state_q == ST_WAIT_HI);
  assign half_addr = slot_addr + ADDR_WID'(hi_half ? HALF_HI_OFS : HALF_LO_OFS);
  assign half_data = hi_half ? latch_q[2*WORD_WID-1:WORD_WID] : latch_q[WORD_WID-1:0];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    latch_d    = latch_q;
    wr_go      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
        end else if (mem_commit) begin
          if (full) begin
            overflow_d = 1'b1;
`ifdef RASTER_PACKER_DROP_EN
            state_d = ST_ACK;
`endif
          end else begin
            latch_d = sample_ext;
            state_d = ST_WR_LO;
          end
        end
      end
      ST_WR_LO: begin
        wr_go = 1'b1;
        if (!dma_finished) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (wr_done) state_d = ST_WR_HI;
      end
      ST_WR_HI: begin
        wr_go = 1'b1;
        if (!dma_finished) state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (wr_done) begin
          wr_ptr_d = wr_ptr_inc;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!mem_commit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      latch_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      latch_q    <= latch_d;
    end
  end

  raster_dma_halfword_writer #(
    .WORD_WID (WORD_WID),
    .ADDR_WID (ADDR_WID)
  ) u_writer (
    .clk          (clk),
    .rst          (rst),
    .go           (wr_go),
    .addr         (half_addr),
    .data         (half_data),
    .done         (wr_done),
    .dma_addr     (dma_addr),
    .dma_data     (dma_data),
    .dma_commit   (dma_commit),
    .dma_finished (dma_finished)
  );

  assign mem_finished = (state_q == ST_ACK);
  assign wr_ptr       = wr_ptr_q;
  assign overflow     = overflow_q;

endmodule
